// File: rtl/fetch_pkg.sv
// Package: fetch_pkg
// Shared types for the fetch sequencer.
//   fs_state_t : sequencer FSM states (IDLE, RUN, DONE)
//   pc_sel_t   : which source feeds the next program counter
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fs_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,  // PC keeps its value
    SEL_START = 3'd1,  // program (re)start
    SEL_RET   = 3'd2,  // return from call
    SEL_CALL  = 3'd3,  // call to target
    SEL_ABS   = 3'd4,  // absolute jump
    SEL_REL   = 3'd5,  // relative branch
    SEL_INC   = 3'd6   // sequential PC+1
  } pc_sel_t;

  // Fixed branch priority: ret > call > abs > rel > increment.
  function automatic pc_sel_t pick_sel(input logic ret_en, input logic call_en,
                                       input logic abs_en, input logic rel_en);
    if (ret_en)       return SEL_RET;
    else if (call_en) return SEL_CALL;
    else if (abs_en)  return SEL_ABS;
    else if (rel_en)  return SEL_REL;
    else              return SEL_INC;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Module: ret_stack
// Hardware return-address LIFO, built as a shift register with entry 0 as
// the top of stack, so the top is always available without a read port.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   clr            empty the stack (contents become don't-care)
//   push, din      push din onto the stack (ignored when full)
//   pop            discard the top entry (ignored when empty)
//   top            current top-of-stack value
//   full, empty    occupancy status
// push and pop are never asserted together by the parent.
module ret_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [W-1:0] ent_reg;
      logic [W-1:0] above;   // value shifted in on push
      logic [W-1:0] below;   // value shifted in on pop

      if (gi == 0) begin : g_first
        assign above = din;
      end else begin : g_rest
        assign above = g_ent[gi-1].ent_reg;
      end

      if (gi == DEPTH - 1) begin : g_last
        assign below = '0;
      end else begin : g_mid
        assign below = g_ent[gi+1].ent_reg;
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ent_reg <= '0;
        end else if (do_push) begin
          ent_reg <= above;
        end else if (do_pop) begin
          ent_reg <= below;
        end
      end
    end
  endgenerate

  assign top = g_ent[0].ent_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (do_push) begin
      count_reg <= count_reg + CW'(1);
    end else if (do_pop) begin
      count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Module: fetch_sequencer
// Program-counter sequencer with start/done handshake, absolute and
// relative branches, call/return through a hardware return stack, and stall.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   req                   start request (acted on in IDLE/DONE only)
//   stall                 freeze PC, stack and flags (RUN only)
//   absjump_en, target    absolute jump to target
//   reljump_en, offset    PC-relative branch by signed offset
//   call_en               push PC+1 and jump to target
//   ret_en                pop return address into PC
//   prog_ctr              current PC (registered)
//   running, done         state indicators, mutually exclusive
//   stack_ovf, stack_unf  sticky call-overflow / ret-underflow flags
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int D         = 10,
  parameter int O         = 8,
  parameter int SD        = 4,
  parameter int START     = 0,
  parameter int HALT_ADDR = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         stall,
  input  logic         absjump_en,
  input  logic [D-1:0] target,
  input  logic         reljump_en,
  input  logic [O-1:0] offset,
  input  logic         call_en,
  input  logic         ret_en,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done,
  output logic         stack_ovf,
  output logic         stack_unf
);

  fs_state_t    state_reg, state_next;
  logic [D-1:0] pc_reg, pc_next;
  logic         ovf_reg, ovf_next;
  logic         unf_reg, unf_next;

  pc_sel_t      sel;
  logic [D-1:0] pc_cand;
  logic [D-1:0] pc_inc;
  logic [D-1:0] off_sext;

  logic         stk_push;
  logic         stk_pop;
  logic         stk_clr;
  logic [D-1:0] stk_top;
  logic         stk_full;
  logic         stk_empty;

  // Arithmetic is naturally modulo 2**D because everything is D bits wide.
  assign pc_inc   = pc_reg + D'(1);
  assign off_sext = D'($signed(offset));

  ret_stack #(
    .W     (D),
    .DEPTH (SD)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .clr   (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_clr    = 1'b0;
    sel        = SEL_HOLD;
    pc_cand    = pc_reg;

    case (state_reg)
      IDLE, DONE: begin
        // A restart wipes every trace of the previous program run.
        if (req) begin
          sel      = SEL_START;
          stk_clr  = 1'b1;
          ovf_next = 1'b0;
          unf_next = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          sel = pick_sel(ret_en, call_en, absjump_en, reljump_en);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (sel)
      SEL_START: pc_cand = D'(START);
      SEL_RET: begin
        if (stk_empty) begin
          // Underflowing return falls through to the next instruction.
          pc_cand  = pc_inc;
          unf_next = 1'b1;
        end else begin
          pc_cand  = stk_top;
          stk_pop  = 1'b1;
        end
      end
      SEL_CALL: begin
        pc_cand = target;
        if (stk_full) begin
          ovf_next = 1'b1;
        end else begin
          stk_push = 1'b1;
        end
      end
      SEL_ABS:  pc_cand = target;
      SEL_REL:  pc_cand = pc_reg + off_sext;
      SEL_INC:  pc_cand = pc_inc;
      default:  pc_cand = pc_reg;
    endcase

    // Any PC update (including a restart) that lands on HALT_ADDR ends the
    // program on the same edge.
    if (sel != SEL_HOLD) begin
      pc_next    = pc_cand;
      state_next = (pc_cand == D'(HALT_ADDR)) ? DONE : RUN;
    end
  end

  assign prog_ctr  = pc_reg;
  assign running   = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign stack_ovf = ovf_reg;
  assign stack_unf = unf_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic       clk;
  logic       reset;
  logic       req, stall, absjump_en, reljump_en, call_en, ret_en;
  logic [9:0] target;
  logic [7:0] offset;
  logic [9:0] prog_ctr;
  logic       running, done, stack_ovf, stack_unf;

  int tests_run = 0;
  int tests_failed = 0;

  fetch_sequencer #(
    .D(10), .O(8), .SD(4), .START(0), .HALT_ADDR(128)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .stall      (stall),
    .absjump_en (absjump_en),
    .target     (target),
    .reljump_en (reljump_en),
    .offset     (offset),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .prog_ctr   (prog_ctr),
    .running    (running),
    .done       (done),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req, stall, abs_en;
    logic [9:0] target;
    logic       rel_en;
    logic [7:0] offset;
    logic       call_en, ret_en;
    logic [9:0] exp_pc;
    logic       exp_run, exp_done, exp_ovf, exp_unf;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic r, logic s, logic a, logic [9:0] t, logic l,
                              logic [7:0] o, logic c, logic rt, logic [9:0] pc,
                              logic er, logic ed, logic eo, logic eu);
    vec_t v;
    v.req = r; v.stall = s; v.abs_en = a; v.target = t; v.rel_en = l;
    v.offset = o; v.call_en = c; v.ret_en = rt; v.exp_pc = pc;
    v.exp_run = er; v.exp_done = ed; v.exp_ovf = eo; v.exp_unf = eu;
    return v;
  endfunction

  task automatic check(input string name, input logic [9:0] epc, input logic er,
                       input logic ed, input logic eo, input logic eu);
    tests_run++;
    if (prog_ctr !== epc || running !== er || done !== ed ||
        stack_ovf !== eo || stack_unf !== eu) begin
      tests_failed++;
      $display("FAIL %s: got pc=%0d run=%0b done=%0b ovf=%0b unf=%0b, want pc=%0d run=%0b done=%0b ovf=%0b unf=%0b",
               name, prog_ctr, running, done, stack_ovf, stack_unf, epc, er, ed, eo, eu);
    end else begin
      $display("[TB] %s ok pc=%0d run=%0b done=%0b ovf=%0b unf=%0b",
               name, prog_ctr, running, done, stack_ovf, stack_unf);
    end
  endtask

  task automatic clear_inputs();
    req = 0; stall = 0; absjump_en = 0; reljump_en = 0; call_en = 0; ret_en = 0;
    target = '0; offset = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 10'd0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Behavioural reference: state 0=idle 1=run 2=done, stack as a queue.
  int m_state, m_pc, m_ovf, m_unf;
  int m_stk[$];

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  task automatic model_step();
    int n, off;
    if (m_state != 1) begin
      if (req) begin
        m_stk.delete();
        m_ovf = 0; m_unf = 0; m_pc = 0;
        m_state = (m_pc == 128) ? 2 : 1;
      end
    end else if (!stall) begin
      if (ret_en) begin
        if (m_stk.size() > 0) n = m_stk.pop_back();
        else begin n = (m_pc + 1) % 1024; m_unf = 1; end
      end else if (call_en) begin
        if (m_stk.size() < 4) m_stk.push_back((m_pc + 1) % 1024);
        else m_ovf = 1;
        n = int'(target);
      end else if (absjump_en) begin
        n = int'(target);
      end else if (reljump_en) begin
        off = offset[7] ? int'(offset) - 256 : int'(offset);
        n = (m_pc + off + 1024) % 1024;
      end else begin
        n = (m_pc + 1) % 1024;
      end
      m_pc = n;
      if (n == 128) m_state = 2;
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;

    // Straight-line count to HALT_ADDR, then restart.
    do_reset();
    req = 1; tick(); req = 0;
    check("count_start", 10'd0, 1, 0, 0, 0);
    for (int i = 1; i <= 128; i++) begin
      tick();
      check($sformatf("count_%0d", i), 10'(i), (i < 128), (i == 128), 0, 0);
    end
    tick();
    check("done_hold", 10'd128, 0, 1, 0, 0);
    req = 1; tick(); req = 0;
    check("restart_after_done", 10'd0, 1, 0, 0, 0);

    // Asynchronous reset in the middle of a run.
    do_reset();
    req = 1; tick(); req = 0;
    repeat (37) tick();
    check("pre_reset_pc37", 10'd37, 1, 0, 0, 0);
    #3 reset = 1'b0;
    #1 check("async_reset", 10'd0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("idle_after_reset", 10'd0, 0, 0, 0, 0);
    req = 1; tick(); req = 0;
    check("restart_after_reset", 10'd0, 1, 0, 0, 0);

    // Directed branch / call / return / stall table.
    //           req s  a  target  l  offset  c  r   pc     run dn ov un
    tbl[0]  = mk(1, 0, 0, 10'd0,   0, 8'h00,  0, 0, 10'd0,    1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 10'd20,  0, 8'h00,  0, 0, 10'd20,   1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 10'd0,   1, 8'hFB,  0, 0, 10'd15,   1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 10'd0,   0, 8'h00,  0, 0, 10'd0,    1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 10'd0,   1, 8'hFF,  0, 0, 10'd1023, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 10'd0,   0, 8'h00,  0, 0, 10'd0,    1, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 10'd10,  0, 8'h00,  0, 0, 10'd10,   1, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 10'd50,  0, 8'h00,  1, 0, 10'd50,   1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 10'd300, 0, 8'h00,  1, 0, 10'd300,  1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 10'd0,   0, 8'h00,  0, 1, 10'd51,   1, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 10'd0,   0, 8'h00,  0, 1, 10'd11,   1, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 10'd0,   0, 8'h00,  0, 1, 10'd12,   1, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 10'd100, 0, 8'h00,  1, 0, 10'd100,  1, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 10'd200, 0, 8'h00,  1, 0, 10'd200,  1, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 10'd300, 0, 8'h00,  1, 0, 10'd300,  1, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 10'd400, 0, 8'h00,  1, 0, 10'd400,  1, 0, 0, 1);
    tbl[16] = mk(0, 0, 0, 10'd500, 0, 8'h00,  1, 0, 10'd500,  1, 0, 1, 1);
    tbl[17] = mk(0, 0, 1, 10'd7,   0, 8'h00,  1, 1, 10'd301,  1, 0, 1, 1);
    tbl[18] = mk(0, 1, 1, 10'd128, 0, 8'h00,  0, 0, 10'd301,  1, 0, 1, 1);
    tbl[19] = mk(0, 1, 1, 10'd128, 0, 8'h00,  0, 0, 10'd301,  1, 0, 1, 1);
    tbl[20] = mk(1, 1, 1, 10'd128, 0, 8'h00,  0, 0, 10'd301,  1, 0, 1, 1);
    tbl[21] = mk(1, 0, 0, 10'd0,   0, 8'h00,  0, 0, 10'd302,  1, 0, 1, 1);
    tbl[22] = mk(0, 0, 1, 10'd128, 0, 8'h00,  0, 0, 10'd128,  0, 1, 1, 1);
    tbl[23] = mk(0, 1, 1, 10'd5,   0, 8'h00,  0, 0, 10'd128,  0, 1, 1, 1);
    tbl[24] = mk(1, 0, 0, 10'd0,   0, 8'h00,  0, 0, 10'd0,    1, 0, 0, 0);
    tbl[25] = mk(0, 0, 0, 10'd0,   0, 8'h00,  0, 1, 10'd1,    1, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 26; i++) begin
      req = tbl[i].req; stall = tbl[i].stall; absjump_en = tbl[i].abs_en;
      target = tbl[i].target; reljump_en = tbl[i].rel_en; offset = tbl[i].offset;
      call_en = tbl[i].call_en; ret_en = tbl[i].ret_en;
      tick();
      check($sformatf("vec_%0d", i), tbl[i].exp_pc, tbl[i].exp_run,
            tbl[i].exp_done, tbl[i].exp_ovf, tbl[i].exp_unf);
    end
    clear_inputs();

    // Randomised run against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      req        = ($urandom_range(0, 7) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      absjump_en = ($urandom_range(0, 5) == 0);
      reljump_en = ($urandom_range(0, 3) == 0);
      call_en    = ($urandom_range(0, 4) == 0);
      ret_en     = ($urandom_range(0, 4) == 0);
      target     = ($urandom_range(0, 7) == 0) ? 10'd128 : 10'($urandom_range(0, 1023));
      offset     = 8'($urandom_range(0, 255));
      model_step();
      tick();
      check($sformatf("rand_%0d", i), 10'(m_pc), (m_state == 1), (m_state == 2),
            m_ovf[0], m_unf[0]);
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
